// File: rtl/divider_pkg.sv
// divider_pkg: shared state encoding and sizing for the 4-bit restoring divider
package divider_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int WIDTH = 4;
  localparam int ITERS = 4;
endpackage

// File: rtl/subtractor5bit.sv
// subtractor5bit: a - b as a + ~b + 1; carry-out high means the difference is non-negative
module subtractor5bit (
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic [4:0] diff,
  output logic       carry
);
  assign {carry, diff} = {1'b0, a} + {1'b0, ~b} + 6'd1;
endmodule

// File: rtl/divider_4bit.sv
// divider_4bit: multicycle restoring unsigned divider, one quotient bit per clock
// Define DIV0_CHECK_EN to short-circuit division by zero and raise div_by_zero.
module divider_4bit
  import divider_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, q_q, q_d, rem_q, rem_d;
  logic [WIDTH:0]   r_q, r_d, shifted, diff;
  logic [1:0]       cnt_q, cnt_d;
  logic             dbz_q, dbz_d, carry, nonneg;
  logic [WIDTH-1:0] a_nx;
  logic [WIDTH:0]   r_nx;

  assign shifted = {r_q[WIDTH-1:0], a_q[WIDTH-1]};

  subtractor5bit u_sub (
    .a    (shifted),
    .b    ({1'b0, b_q}),
    .diff (diff),
    .carry(carry)
  );

  // a set bit above the shifted window would already exceed any divisor
  assign nonneg = carry | r_q[WIDTH];
  assign a_nx   = {a_q[WIDTH-2:0], nonneg};
  assign r_nx   = nonneg ? diff : shifted;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CALC;
        a_d     = dividend;
        b_d     = divisor;
        r_d     = '0;
        cnt_d   = '0;
      end
      CALC: begin
        a_d   = a_nx;
        r_d   = r_nx;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(ITERS - 1)) begin
          state_d = DONE;
          q_d     = a_nx;
          rem_d   = r_nx[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
`ifdef DIV0_CHECK_EN
        if (b_q == '0) begin
          state_d = DONE;
          q_d     = '1;
          rem_d   = a_q;
          dbz_d   = 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = q_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
endmodule

// File: tb/tb_divider_4bit.sv
// tb_divider_4bit: directed and exhaustive checks of divider_4bit
module tb_divider_4bit;
`ifdef DIV0_CHECK_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0] dividend = '0, divisor = '0, quotient, remainder;
  logic busy, done, div_by_zero;
  int errors = 0, checks = 0;

  divider_4bit dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [3:0] dd, input logic [3:0] dv, output int lat, output int nb);
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    nb  = 0;
    while (!done && lat < 20) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic full_check(input string tag, input logic [3:0] dd, input logic [3:0] dv,
                            input logic [3:0] eq, input logic [3:0] er);
    int lat, nb;
    bit z;
    z = (dv == 4'd0) && DZ;
    run(dd, dv, lat, nb);
    chk({tag, " latency"}, 16'(lat), z ? 16'd1 : 16'd4);
    chk({tag, " busy cycles"}, 16'(nb), z ? 16'd1 : 16'd4);
    chk({tag, " quotient"}, 16'(quotient), 16'(eq));
    chk({tag, " remainder"}, 16'(remainder), 16'(er));
    chk({tag, " div_by_zero"}, 16'(div_by_zero), 16'(z));
    @(negedge clk);
    chk({tag, " done width"}, 16'({done, busy}), 16'd0);
  endtask

  initial begin
    int lat, nb, pulses;
    logic [3:0] eq, er;
    repeat (2) @(negedge clk);
    chk("reset outputs", {quotient, remainder, 5'(0), busy, done, div_by_zero}, 16'd0);
    dividend = 4'd5;
    divisor  = 4'd1;
    start    = 1'b1;
    @(negedge clk);
    chk("reset beats start", 16'(busy), 16'd0);
    start = 1'b0;
    reset = 1'b0;

    full_check("13/4", 4'd13, 4'd4, 4'd3, 4'd1);
    full_check("15/1", 4'd15, 4'd1, 4'd15, 4'd0);
    full_check("3/7", 4'd3, 4'd7, 4'd0, 4'd3);
    full_check("9/0", 4'd9, 4'd0, 4'hF, 4'd9);

    // start during CALC must be ignored
    @(negedge clk);
    dividend = 4'd13;
    divisor  = 4'd4;
    start    = 1'b1;
    @(negedge clk);
    dividend = 4'd6;
    divisor  = 4'd2;
    @(negedge clk);
    start  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    chk("ignored start pulses", 16'(pulses), 16'd1);
    chk("ignored start result", {8'd0, quotient, remainder}, 16'h0031);

    // reset at N+2 aborts
    dividend = 4'd13;
    divisor  = 4'd4;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort outputs", {quotient, remainder, 5'(0), busy, done, div_by_zero}, 16'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) pulses++;
      @(negedge clk);
    end
    chk("abort no activity", 16'(pulses), 16'd0);
    full_check("14/3", 4'd14, 4'd3, 4'd4, 4'd2);

    for (int dd = 0; dd < 16; dd++) begin
      for (int dv = 0; dv < 16; dv++) begin
        eq = (dv == 0) ? 4'hF : 4'(dd / dv);
        er = (dv == 0) ? 4'(dd) : 4'(dd % dv);
        run(4'(dd), 4'(dv), lat, nb);
        chk($sformatf("ex %0d/%0d latency", dd, dv), 16'(lat),
            (dv == 0 && DZ) ? 16'd1 : 16'd4);
        chk($sformatf("ex %0d/%0d result", dd, dv), {8'd0, quotient, remainder}, {8'd0, eq, er});
        repeat (3) @(negedge clk);
        chk($sformatf("ex %0d/%0d hold", dd, dv),
            {7'd0, div_by_zero, quotient, remainder}, {7'd0, DZ && dv == 0, eq, er});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/divider_4bit.md
DIVIDER_4BIT -- requirements
Module: divider_4bit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have port dividend, input, 4 bits: unsigned dividend, sampled with start.
REQ-005 SHALL have port divisor, input, 4 bits: unsigned divisor, sampled with start.
REQ-006 SHALL have port quotient, output, 4 bits: registered result.
REQ-007 SHALL have port remainder, output, 4 bits: registered result.
REQ-008 SHALL have port busy, output, 1 bit: high while in CALC.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse while in DONE.
REQ-010 SHALL have port div_by_zero, output, 1 bit: registered flag, updated with results.

Function
REQ-011 SHALL implement states IDLE, CALC and DONE.
REQ-012 SHALL, when start=1 at edge N in IDLE, enter CALC, latch dividend and divisor, clear the 5-bit partial remainder and clear the 2-bit iteration counter.
REQ-013 SHALL perform one restoring step per edge in CALC: shift {R,A} left one bit, compute R-divisor at 5 bits, keep the difference and set the quotient bit to 1 if non-negative, else restore R and set the quotient bit to 0.
REQ-014 SHALL perform steps at edges N+1..N+4 and enter DONE at N+4, loading quotient and remainder at that same edge.
REQ-015 SHALL drive done=1 only during the cycle after edge N+4, then return to IDLE at N+5.
REQ-016 SHALL hold quotient, remainder and div_by_zero unchanged from the DONE load until the next DONE load or reset.
REQ-017 SHALL ignore start in CALC and DONE; no queuing; back-to-back operations require start in IDLE.
REQ-018 SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for every divisor != 0.
REQ-019 SHALL keep busy=1 exactly while in CALC.

Reset
REQ-020 SHALL, on reset=1 at any edge, force IDLE and set quotient, remainder, partial state, counter, busy, done and div_by_zero to 0.
REQ-021 SHALL abort any operation on reset mid-CALC or in DONE with no done pulse, and SHALL give reset priority over a simultaneous start.

Configuration
REQ-022 SHALL, with DIV0_CHECK_EN defined, go from CALC straight to DONE at edge N+1 when the latched divisor is 0, loading quotient=4'hF, remainder=dividend and div_by_zero=1.
REQ-023 SHALL, without DIV0_CHECK_EN, run the normal 4 steps for divisor 0, giving quotient=4'hF and remainder=dividend at N+4, with div_by_zero tied to 0.

Structure
REQ-024 SHALL take the state enumeration, the width constant (4) and the iteration count constant (4) from shared package divider_pkg.
REQ-025 SHALL compute the step subtraction in one combinational sub-module, subtractor5bit, as A + ~B + 1, whose carry-out indicates a non-negative result.

Verification
REQ-026 SHALL cover: dividend=13, divisor=4, start at edge N -> quotient=3, remainder=1, done high only after N+4, busy high N..N+4.
REQ-027 SHALL cover: 15/1 -> quotient=15, remainder=0; and 3/7 -> quotient=0, remainder=3.
REQ-028 SHALL cover: 9/0 -> with DIV0_CHECK_EN, quotient=4'hF, remainder=9, div_by_zero=1, done after N+1; without it, same quotient and remainder, div_by_zero=0, done after N+4.
REQ-029 SHALL cover: start pulsed with 6/2 during CALC of 13/4 -> ignored, results 3/1, one done pulse only.
REQ-030 SHALL cover: reset at N+2 of 13/4 -> all outputs 0, no done; new start 14/3 -> quotient=4, remainder=2.
REQ-031 SHALL cover: exhaustive 256 dividend/divisor pairs checked against a reference model, with results holding stable between operations.
